t03_mem_arbiter: RTL and testbench

- Arbitrates the CPU's instruction-fetch port and data-memory port onto the single request interface of the team's Wishbone manager.
- Sits directly upstream of the manager.
- Serialises requests, holds address, data and select stable for the whole bus transaction, and captures the manager's registered read data.
- Returns a one-cycle ready pulse to the port that was served; grant is round-robin when both ports request together.

---
 rtl/t03_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_t03_mem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/t03_mem_arbiter.sv
// ---------------------------------------------------------------------------
// t03_mem_arbiter : round-robin arbiter of CPU fetch/data ports onto one
//                   Wishbone manager request interface.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module t03_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_adr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_sel,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mgr_read,
  output logic              mgr_write,
  output logic [ADDR_W-1:0] mgr_adr,
  output logic [DATA_W-1:0] mgr_wdata,
  output logic [3:0]        mgr_sel,
  input  logic              mgr_busy,
  input  logic              mgr_ack,
  input  logic [DATA_W-1:0] mgr_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_data_q, gnt_data_d;
  logic                last_data_q, last_data_d;
  logic                wr_q, wr_d;
  logic                mgr_read_q, mgr_read_d;
  logic                mgr_write_q, mgr_write_d;
  logic [ADDR_W-1:0]   mgr_adr_q, mgr_adr_d;
  logic [DATA_W-1:0]   mgr_wdata_q, mgr_wdata_d;
  logic [3:0]          mgr_sel_q, mgr_sel_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                i_pend, d_pend, pick_data, rd_capture;

  assign i_pend    = i_read;
  assign d_pend    = d_read | d_write;
  // On contention the port that was not served last wins.
  assign pick_data = d_pend & (~i_pend | ~last_data_q);

  always_comb begin
    state_d     = state_q;
    gnt_data_d  = gnt_data_q;
    last_data_d = last_data_q;
    wr_d        = wr_q;
    mgr_read_d  = 1'b0;
    mgr_write_d = 1'b0;
    mgr_adr_d   = mgr_adr_q;
    mgr_wdata_d = mgr_wdata_q;
    mgr_sel_d   = mgr_sel_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (!mgr_busy && (i_pend || d_pend)) begin
          gnt_data_d  = pick_data;
          last_data_d = pick_data;
          wr_d        = pick_data & d_write;
          mgr_adr_d   = pick_data ? d_adr : i_adr;
          mgr_wdata_d = pick_data ? d_wdata : '0;
          mgr_sel_d   = pick_data ? d_sel : 4'hF;
          mgr_write_d = pick_data & d_write;
          mgr_read_d  = ~(pick_data & d_write);
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mgr_ack) begin
          i_ready_d = ~gnt_data_q;
          d_ready_d = gnt_data_q;
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!wr_q) begin
          if (gnt_data_q) d_rdata_d = mgr_rdata;
          else            i_rdata_d = mgr_rdata;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      gnt_data_q  <= 1'b0;
      last_data_q <= 1'b1;
      wr_q        <= 1'b0;
      mgr_read_q  <= 1'b0;
      mgr_write_q <= 1'b0;
      mgr_adr_q   <= '0;
      mgr_wdata_q <= '0;
      mgr_sel_q   <= 4'h0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_data_q  <= gnt_data_d;
      last_data_q <= last_data_d;
      wr_q        <= wr_d;
      mgr_read_q  <= mgr_read_d;
      mgr_write_q <= mgr_write_d;
      mgr_adr_q   <= mgr_adr_d;
      mgr_wdata_q <= mgr_wdata_d;
      mgr_sel_q   <= mgr_sel_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // The manager's read data is itself registered and only valid during the
  // ready cycle, so it is forwarded then and held by the rdata register after.
  assign rd_capture = (state_q == S_CAPTURE) & ~wr_q;

  assign i_rdata   = (rd_capture & ~gnt_data_q) ? mgr_rdata : i_rdata_q;
  assign d_rdata   = (rd_capture &  gnt_data_q) ? mgr_rdata : d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign mgr_read  = mgr_read_q;
  assign mgr_write = mgr_write_q;
  assign mgr_adr   = mgr_adr_q;
  assign mgr_wdata = mgr_wdata_q;
  assign mgr_sel   = mgr_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_t03_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_t03_mem_arbiter : directed self-checking bench for t03_mem_arbiter.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_t03_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        i_read, d_read, d_write;
  logic [31:0] i_adr, d_adr, d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ready, d_ready;
  logic        mgr_read, mgr_write;
  logic [31:0] mgr_adr, mgr_wdata;
  logic [3:0]  mgr_sel;
  logic        mgr_busy, mgr_ack;
  logic [31:0] mgr_rdata;

  int vectors     = 0;
  int miscompares = 0;

  t03_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_read(i_read), .i_adr(i_adr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_sel(d_sel), .d_rdata(d_rdata), .d_ready(d_ready),
    .mgr_read(mgr_read), .mgr_write(mgr_write), .mgr_adr(mgr_adr),
    .mgr_wdata(mgr_wdata), .mgr_sel(mgr_sel), .mgr_busy(mgr_busy),
    .mgr_ack(mgr_ack), .mgr_rdata(mgr_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Plays the slave side of one transaction and returns in the ready cycle.
  task automatic serve(input int lat, input bit spur, input bit exp_d, input bit exp_w,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic [3:0] sel, input logic [31:0] rd);
    int n;
    n = 0;
    tick();
    while (!(mgr_read || mgr_write) && n < 20) begin
      tick();
      n++;
    end
    chk("strobe_seen", 32'(mgr_read | mgr_write), 32'd1);
    if (!(mgr_read || mgr_write)) return;
    chk("mgr_read", 32'(mgr_read), 32'(!exp_w));
    chk("mgr_write", 32'(mgr_write), 32'(exp_w));
    chk("mgr_adr", mgr_adr, adr);
    chk("mgr_wdata", mgr_wdata, wd);
    chk("mgr_sel", 32'(mgr_sel), 32'(sel));
    if (spur) mgr_ack = 1'b1;
    tick();
    mgr_ack = 1'b0;
    chk("strobe_drop", 32'({mgr_read, mgr_write}), 32'd0);
    repeat (lat) begin
      chk("hold_adr", mgr_adr, adr);
      chk("hold_wdata", mgr_wdata, wd);
      chk("hold_sel", 32'(mgr_sel), 32'(sel));
      chk("no_early_ready", 32'({i_ready, d_ready}), 32'd0);
      tick();
    end
    chk("hold_adr_ack", mgr_adr, adr);
    mgr_ack = 1'b1;
    tick();
    mgr_ack   = 1'b0;
    mgr_rdata = rd;
    #1;
    chk("i_ready", 32'(i_ready), 32'(!exp_d));
    chk("d_ready", 32'(d_ready), 32'(exp_d));
    if (!exp_w) begin
      if (exp_d) chk("d_rdata", d_rdata, rd);
      else       chk("i_rdata", i_rdata, rd);
    end
  endtask

  initial begin
    nRST = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_adr = '0; d_adr = '0; d_wdata = '0; d_sel = '0;
    mgr_busy = 1'b0; mgr_ack = 1'b0; mgr_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_strobes", 32'({mgr_read, mgr_write, i_ready, d_ready}), 32'd0);
    chk("rst_adr", mgr_adr, 32'd0);
    chk("rst_sel", 32'(mgr_sel), 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    nRST = 1'b1;
    tick();

    // Single fetch, manager busy for two cycles first, spurious ack in ISSUE
    mgr_busy = 1'b1;
    i_read = 1'b1; i_adr = 32'h0000_0100;
    tick();
    chk("busy_hold", 32'({mgr_read, mgr_write}), 32'd0);
    tick();
    chk("busy_hold2", 32'({mgr_read, mgr_write}), 32'd0);
    mgr_busy = 1'b0;
    serve(0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hDEAD_BEEF);
    i_read = 1'b0;
    tick();
    chk("fetch_ready_pulse", 32'({i_ready, d_ready}), 32'd0);
    chk("fetch_rdata_held", i_rdata, 32'hDEAD_BEEF);

    // Store
    d_write = 1'b1; d_adr = 32'h2000_0004; d_wdata = 32'h1234_5678; d_sel = 4'b0011;
    serve(2, 1'b0, 1'b1, 1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF);
    chk("store_d_rdata", d_rdata, 32'd0);
    d_write = 1'b0;
    tick();
    chk("store_d_rdata_after", d_rdata, 32'd0);
    chk("store_i_rdata_held", i_rdata, 32'hDEAD_BEEF);

    // Read+write conflict: store wins
    d_read = 1'b1; d_write = 1'b1; d_adr = 32'h0000_0030; d_wdata = 32'hCAFE_F00D; d_sel = 4'hF;
    serve(1, 1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 32'h5555_5555);
    d_read = 1'b0; d_write = 1'b0;
    tick();
    chk("conflict_one_ready", 32'(d_ready), 32'd0);
    chk("conflict_d_rdata", d_rdata, 32'd0);

    // Data load with five wait states
    d_read = 1'b1; d_adr = 32'h0000_0044; d_wdata = 32'hA5A5_A5A5; d_sel = 4'b1100;
    serve(5, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'hA5A5_A5A5, 4'b1100, 32'h0BAD_F00D);
    d_read = 1'b0;
    tick();
    chk("load_rdata_held", d_rdata, 32'h0BAD_F00D);
    chk("load_ready_pulse", 32'({i_ready, d_ready}), 32'd0);

    // Reset in the middle of WAIT
    i_read = 1'b1; i_adr = 32'h0000_0200;
    tick();
    chk("midrst_issue", 32'(mgr_read), 32'd1);
    tick();
    nRST = 1'b0;
    #1;
    chk("midrst_strobes", 32'({mgr_read, mgr_write, i_ready, d_ready}), 32'd0);
    chk("midrst_adr", mgr_adr, 32'd0);
    chk("midrst_rdata", i_rdata | d_rdata, 32'd0);
    mgr_ack = 1'b1;
    tick();
    mgr_ack = 1'b0;
    tick();
    chk("midrst_no_ready", 32'({i_ready, d_ready}), 32'd0);

    // Contention after reset: I, D, I, D
    i_adr = 32'h0000_1000; d_adr = 32'h0000_2000; d_wdata = 32'h0; d_sel = 4'hF;
    d_read = 1'b1;
    nRST = 1'b1;
    serve(0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'h1111_1111);
    serve(1, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'h2222_2222);
    serve(0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'h3333_3333);
    serve(2, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'h4444_4444);
    i_read = 1'b0; d_read = 1'b0;
    tick();
    chk("cont_i_rdata", i_rdata, 32'h3333_3333);
    chk("cont_d_rdata", d_rdata, 32'h4444_4444);
    tick();
    chk("idle_quiet", 32'({mgr_read, mgr_write, i_ready, d_ready}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
